// File: rtl/pin_ctrl_pkg.sv
// Shared state encoding, key codes and key-decode helper for the PIN entry controller.
package pin_ctrl_pkg;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        SET_NEW = 3'd3,
        LOCKOUT = 3'd4
    } pin_state_t;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter that holds at zero; one instance serves both the open and lockout timeouts.
module countdown_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         zero,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero  = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/pin_entry_ctrl.sv
// PIN entry sequencer: buffers keypad digits, checks them against the stored PIN,
// drives open/lock outcome, supports changing the PIN while open and enforces lockout.
module pin_entry_ctrl
    import pin_ctrl_pkg::*;
#(
    parameter int                   PIN_LEN     = 4,
    parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN = 16'h1234,
    parameter int                   MAX_FAIL    = 3,
    parameter int                   LOCK_TICKS  = 500_000_000,
    parameter int                   OPEN_TICKS  = 250_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    input  logic [3:0]           key_value,
    output logic [2:0]           state,
    output logic [4*PIN_LEN-1:0] digit_buf,
    output logic [3:0]           digit_cnt,
    output logic                 door_open,
    output logic                 unlock_pulse,
    output logic                 fail_pulse,
    output logic                 locked,
    output logic [3:0]           fail_cnt
);

    localparam int BUF_W     = 4 * PIN_LEN;
    localparam int MAX_TICKS = (LOCK_TICKS > OPEN_TICKS) ? LOCK_TICKS : OPEN_TICKS;
    localparam int TMR_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_TICKS - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_TICKS - 1);

    pin_state_t       cur_state, nxt_state;
    logic [BUF_W-1:0] digit_buf_q;
    logic [BUF_W-1:0] stored_pin;
    logic [3:0]       digit_cnt_q;
    logic [3:0]       fail_cnt_q;
    logic             unlock_q, fail_q, door_q, locked_q;

    logic             key_digit, key_star, key_hash;
    logic             buf_full, buf_empty, pin_match, fail_limit;
    logic [3:0]       fail_next;

    logic             buf_push, buf_pop, buf_clr, pin_store;
    logic             fail_inc, fail_clr, unlock_d, fail_d;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0] tmr_load_val;
    logic [TMR_W-1:0] tmr_count_unused;

    assign key_digit  = key_valid && is_digit(key_value);
    assign key_star   = key_valid && (key_value == KEY_STAR);
    assign key_hash   = key_valid && (key_value == KEY_HASH);

    assign buf_full   = (digit_cnt_q == 4'(PIN_LEN));
    assign buf_empty  = (digit_cnt_q == 4'd0);
    assign pin_match  = buf_full && (digit_buf_q == stored_pin);
    assign fail_next  = fail_cnt_q + 4'd1;
    assign fail_limit = (fail_next == 4'(MAX_FAIL));

    countdown_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .enable   (tmr_en),
        .zero     (tmr_zero),
        .count    (tmr_count_unused)
    );

    assign tmr_en = (cur_state == OPEN) || (cur_state == LOCKOUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= ENTRY;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ENTRY: begin
                if (key_hash) nxt_state = CHECK;
            end
            CHECK: begin
                if (pin_match)       nxt_state = OPEN;
                else if (fail_limit) nxt_state = LOCKOUT;
                else                 nxt_state = ENTRY;
            end
            OPEN: begin
                // Timeout and '#' both relock; '*' only matters when neither happened.
                if (tmr_zero || key_hash) nxt_state = ENTRY;
                else if (key_star)        nxt_state = SET_NEW;
            end
            SET_NEW: begin
                if (key_hash && buf_full) nxt_state = ENTRY;
            end
            LOCKOUT: begin
                if (tmr_zero) nxt_state = ENTRY;
            end
            default: nxt_state = ENTRY;
        endcase
    end

    always_comb begin
        buf_push     = 1'b0;
        buf_pop      = 1'b0;
        buf_clr      = 1'b0;
        pin_store    = 1'b0;
        fail_inc     = 1'b0;
        fail_clr     = 1'b0;
        unlock_d     = 1'b0;
        fail_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (cur_state)
            ENTRY: begin
                buf_push = key_digit && !buf_full;
                buf_pop  = key_star && !buf_empty;
            end
            CHECK: begin
                buf_clr = 1'b1;
                if (pin_match) begin
                    unlock_d     = 1'b1;
                    fail_clr     = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = OPEN_LOAD;
                end else begin
                    fail_d   = 1'b1;
                    fail_inc = 1'b1;
                    if (fail_limit) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = LOCK_LOAD;
                    end
                end
            end
            OPEN: begin
                buf_clr = key_star;
            end
            SET_NEW: begin
                buf_push = key_digit && !buf_full;
                buf_pop  = key_star && !buf_empty;
                if (key_hash && buf_full) begin
                    pin_store = 1'b1;
                    buf_clr   = 1'b1;
                end
            end
            LOCKOUT: begin
                fail_clr = tmr_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_buf_q <= '0;
            digit_cnt_q <= 4'd0;
            stored_pin  <= DEFAULT_PIN;
            fail_cnt_q  <= 4'd0;
            unlock_q    <= 1'b0;
            fail_q      <= 1'b0;
            door_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            if (buf_clr) begin
                digit_buf_q <= '0;
                digit_cnt_q <= 4'd0;
            end else if (buf_push) begin
                digit_buf_q <= {digit_buf_q[BUF_W-5:0], key_value};
                digit_cnt_q <= digit_cnt_q + 4'd1;
            end else if (buf_pop) begin
                digit_buf_q <= digit_buf_q >> 4;
                digit_cnt_q <= digit_cnt_q - 4'd1;
            end

            if (pin_store) stored_pin <= digit_buf_q;

            if (fail_clr)      fail_cnt_q <= 4'd0;
            else if (fail_inc) fail_cnt_q <= fail_next;

            // Status flags follow the state with one cycle of latency.
            unlock_q <= unlock_d;
            fail_q   <= fail_d;
            door_q   <= (cur_state == OPEN) || (cur_state == SET_NEW);
            locked_q <= (cur_state == LOCKOUT);
        end
    end

    assign state        = cur_state;
    assign digit_buf    = digit_buf_q;
    assign digit_cnt    = digit_cnt_q;
    assign door_open    = door_q;
    assign unlock_pulse = unlock_q;
    assign fail_pulse   = fail_q;
    assign locked       = locked_q;
    assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: directed sessions with literal expectations, then random key traffic
// checked every cycle against a queue-based session model.
module tb_pin_entry_ctrl;
    import pin_ctrl_pkg::*;

    localparam int PIN_LEN    = 4;
    localparam int MAX_FAIL   = 3;
    localparam int LOCK_TICKS = 30;
    localparam int OPEN_TICKS = 20;
    localparam logic [15:0] DEF_PIN = 16'h1234;

    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_SET = 3, M_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_value = 4'd0;
    logic [2:0]  state;
    logic [15:0] digit_buf;
    logic [3:0]  digit_cnt;
    logic        door_open, unlock_pulse, fail_pulse, locked;
    logic [3:0]  fail_cnt;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    pin_entry_ctrl #(
        .PIN_LEN     (PIN_LEN),
        .DEFAULT_PIN (DEF_PIN),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_TICKS  (LOCK_TICKS),
        .OPEN_TICKS  (OPEN_TICKS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_value    (key_value),
        .state        (state),
        .digit_buf    (digit_buf),
        .digit_cnt    (digit_cnt),
        .door_open    (door_open),
        .unlock_pulse (unlock_pulse),
        .fail_pulse   (fail_pulse),
        .locked       (locked),
        .fail_cnt     (fail_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Session model: digits kept as a queue, timers as "cycles remaining".
    int  m_state, m_fails, m_remain;
    int  m_q[$];
    int  m_pin[PIN_LEN];
    bit  m_unlock, m_fail, m_door, m_lock;
    bit  model_ok = 1'b0;

    function automatic logic [31:0] model_buf();
        logic [31:0] b = 32'd0;
        foreach (m_q[i]) b = (b << 4) | 32'(m_q[i]);
        return b;
    endfunction

    always @(posedge clk) begin : model
        int  prev;
        bit  ok;
        if (!rst_n) begin
            m_state = M_ENTRY; m_fails = 0; m_remain = 0; m_q.delete();
            for (int i = 0; i < PIN_LEN; i++) m_pin[i] = int'((DEF_PIN >> (4 * (PIN_LEN - 1 - i))) & 16'hF);
            m_unlock = 0; m_fail = 0; m_door = 0; m_lock = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            prev = m_state;
            m_unlock = 0; m_fail = 0;
            case (m_state)
                M_ENTRY, M_SET: begin
                    if (key_valid) begin
                        if (key_value <= 4'd9) begin
                            if (m_q.size() < PIN_LEN) m_q.push_back(int'(key_value));
                        end else if (key_value == KEY_STAR) begin
                            if (m_q.size() > 0) void'(m_q.pop_back());
                        end else if (key_value == KEY_HASH) begin
                            if (m_state == M_ENTRY) m_state = M_CHECK;
                            else if (m_q.size() == PIN_LEN) begin
                                for (int i = 0; i < PIN_LEN; i++) m_pin[i] = m_q[i];
                                m_q.delete();
                                m_state = M_ENTRY;
                            end
                        end
                    end
                end
                M_CHECK: begin
                    ok = (m_q.size() == PIN_LEN);
                    if (ok) for (int i = 0; i < PIN_LEN; i++) if (m_q[i] != m_pin[i]) ok = 0;
                    m_q.delete();
                    if (ok) begin
                        m_unlock = 1; m_fails = 0; m_remain = OPEN_TICKS; m_state = M_OPEN;
                    end else begin
                        m_fail = 1; m_fails++;
                        if (m_fails == MAX_FAIL) begin m_remain = LOCK_TICKS; m_state = M_LOCK; end
                        else m_state = M_ENTRY;
                    end
                end
                M_OPEN: begin
                    m_remain--;
                    if (m_remain == 0 || (key_valid && key_value == KEY_HASH)) m_state = M_ENTRY;
                    else if (key_valid && key_value == KEY_STAR) begin m_q.delete(); m_state = M_SET; end
                end
                M_LOCK: begin
                    m_remain--;
                    if (m_remain == 0) begin m_fails = 0; m_state = M_ENTRY; end
                end
                default: m_state = M_ENTRY;
            endcase
            m_door = (prev == M_OPEN) || (prev == M_SET);
            m_lock = (prev == M_LOCK);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("state",        32'(state),        32'(m_state));
            check("digit_buf",    32'(digit_buf),    model_buf());
            check("digit_cnt",    32'(digit_cnt),    32'(m_q.size()));
            check("door_open",    32'(door_open),    32'(m_door));
            check("unlock_pulse", 32'(unlock_pulse), 32'(m_unlock));
            check("fail_pulse",   32'(fail_pulse),   32'(m_fail));
            check("locked",       32'(locked),       32'(m_lock));
            check("fail_cnt",     32'(fail_cnt),     32'(m_fails));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic press(input logic [3:0] k);
        @(posedge clk); #1; key_valid = 1'b1; key_value = k;
        @(posedge clk); #1; key_valid = 1'b0;
    endtask

    task automatic press_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "*")      press(KEY_STAR);
            else if (s[i] == "#") press(KEY_HASH);
            else                  press(4'(s[i] - "0"));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1; key_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},  32'(state), 32'd0);
        check({tag, "_buf"},    32'(digit_buf), 32'd0);
        check({tag, "_cnt"},    32'(digit_cnt), 32'd0);
        check({tag, "_door"},   32'(door_open), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_unlock"}, 32'(unlock_pulse), 32'd0);
        check({tag, "_failp"},  32'(fail_pulse), 32'd0);
        check({tag, "_failc"},  32'(fail_cnt), 32'd0);
    endtask

    function automatic logic [3:0] rand_key();
        int w = $urandom_range(0, 99);
        if (w < 55) return 4'($urandom_range(0, 9));
        if (w < 70) return KEY_STAR;
        if (w < 85) return KEY_HASH;
        return 4'($urandom_range(12, 15));
    endfunction

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        check_reset_values("rst0");

        // Correct PIN, then automatic relock after OPEN_TICKS cycles
        press_str("1234#");
        tick();
        check("t1_unlock", 32'(unlock_pulse), 32'd1);
        check("t1_state_open", 32'(state), 32'd2);
        check("t1_failcnt", 32'(fail_cnt), 32'd0);
        tick();
        check("t1_door", 32'(door_open), 32'd1);
        repeat (18) tick();
        check("t1_still_open", 32'(state), 32'd2);
        tick();
        check("t1_relock", 32'(state), 32'd0);

        // Backspace, then overflow of the digit buffer
        press_str("125*34#");
        tick();
        check("t2_unlock", 32'(unlock_pulse), 32'd1);
        press_str("#");
        press_str("12345");
        check("t2_cnt_full", 32'(digit_cnt), 32'd4);
        check("t2_buf_full", 32'(digit_buf), 32'h1234);
        do_reset();

        // Three failures trigger lockout; keys during lockout are ignored
        for (int i = 1; i <= 3; i++) begin
            press_str("9999#");
            tick();
            check("t3_failp", 32'(fail_pulse), 32'd1);
            check("t3_failcnt", 32'(fail_cnt), 32'(i));
        end
        check("t3_state_lock", 32'(state), 32'd4);
        tick();
        check("t3_locked", 32'(locked), 32'd1);
        press_str("12#");
        repeat (22) tick();
        check("t3_still_lock", 32'(state), 32'd4);
        tick();
        check("t3_exit", 32'(state), 32'd0);
        check("t3_failclr", 32'(fail_cnt), 32'd0);

        // PIN change, old PIN rejected, new PIN accepted
        do_reset();
        press_str("1234#");
        tick();
        press_str("*5678#");
        check("t4_back_entry", 32'(state), 32'd0);
        press_str("1234#");
        tick();
        check("t4_old_fails", 32'(fail_pulse), 32'd1);
        press_str("5678#");
        tick();
        check("t4_new_unlocks", 32'(unlock_pulse), 32'd1);

        // Short entry fails; short new PIN is refused
        do_reset();
        press_str("12#");
        tick();
        check("t5_short_fail", 32'(fail_pulse), 32'd1);
        check("t5_failcnt", 32'(fail_cnt), 32'd1);
        press_str("1234#");
        tick();
        press_str("*56#");
        check("t5_set_state", 32'(state), 32'd3);
        check("t5_set_cnt", 32'(digit_cnt), 32'd2);
        check("t5_set_buf", 32'(digit_buf), 32'h56);

        // Reset in the middle of a PIN change restores the default PIN
        do_reset();
        check_reset_values("rst6");
        press_str("1234#");
        tick();
        check("t6_default_unlock", 32'(unlock_pulse), 32'd1);

        // Random traffic against the model
        for (int it = 0; it < 700; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 25) begin
                for (int i = 0; i < PIN_LEN; i++) press(4'(m_pin[i]));
                press(KEY_HASH);
            end else begin
                @(posedge clk); #1;
                key_valid = 1'($urandom_range(0, 1));
                key_value = rand_key();
            end
        end
        @(posedge clk); #1; key_valid = 1'b0; key_value = KEY_NONE;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
